hex_display_ctrl: RTL



---
 rtl/hex_display_pkg.sv | 15 +
 rtl/sevenseg.sv | 33 +++
 rtl/hex_display_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared types and constants for the HEX display controller
package hex_display_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   localparam int         DIGIT_W = 4;
   localparam int         SEG_W   = 7;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] HEX_OFF = 8'hFF;

endpackage

// File: rtl/sevenseg.sv
// rtl/sevenseg.sv - hex nibble to active-low seven-segment decoder {g,f,e,d,c,b,a}
module sevenseg
   import hex_display_pkg::*;
(
   input  logic [DIGIT_W-1:0] data_i,
   output logic [SEG_W-1:0]   seg_o
);

   // Pure lookup; a segment is lit when its bit is 0.
   always_comb begin
      seg_o = SEG_OFF;
      case (data_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - scans a packed hex value through one shared decoder and commits all digits at once
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    lz_en,
   input  logic                    blink_en,
   output logic [8*NUM_DIGITS-1:0] hex,
   output logic                    busy
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam int HEX_W = 8*NUM_DIGITS;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    lz_q, lz_d;
   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]   bm_q, bm_d;
   logic [NUM_DIGITS-1:0]   dm_q, dm_d;
   logic [HEX_W-1:0]        shadow_q, shadow_d;
   logic [HEX_W-1:0]        hex_q, hex_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    phase_on_q, phase_on_d;

   logic [DIGIT_W-1:0]      nibble;
   logic                    cur_bm;
   logic                    cur_dm;
   logic [SEG_W-1:0]        dec_seg;
   logic                    blank;
   logic [7:0]              digit_byte;

   // Single decoder shared by every digit; its input follows the scan index.
   sevenseg u_dec (
      .data_i (nibble),
      .seg_o  (dec_seg)
   );

   // Pick the captured nibble and mask bits of the digit currently being scanned.
   always_comb begin
      nibble = '0;
      cur_bm = 1'b0;
      cur_dm = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nibble = val_q[i*DIGIT_W +: DIGIT_W];
            cur_bm = bm_q[i];
            cur_dm = dm_q[i];
         end
      end
   end

   // Shadow byte for the scanned digit; a leading-zero blank keeps a requested dp.
   always_comb begin
      blank      = cur_bm | (lz_q & (nibble == '0) & (idx_q != '0));
      digit_byte = {~(cur_dm & ~cur_bm), (blank ? SEG_OFF : dec_seg)};
   end

   // Sequencer next state: capture in IDLE, one digit per cycle in SCAN, publish in COMMIT.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      lz_d       = lz_q;
      val_d      = val_q;
      bm_d       = bm_q;
      dm_d       = dm_q;
      shadow_d   = shadow_q;
      hex_d      = hex_q;
      load_ready = 1'b0;
      busy       = 1'b0;
      case (state_q)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               val_d   = value;
               bm_d    = blank_mask;
               dm_d    = dp_mask;
               lz_d    = lz_en;
               idx_d   = IDX_W'(NUM_DIGITS-1);
               state_d = SCAN;
            end
         end
         SCAN: begin
            busy = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  shadow_d[i*8 +: 8] = digit_byte;
               end
            end
            if (nibble != '0) begin
               lz_d = 1'b0;
            end
            if (idx_q == '0) begin
               state_d = COMMIT;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         COMMIT: begin
            busy    = 1'b1;
            hex_d   = shadow_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Free-running blink divider, independent of the sequencer.
   always_comb begin
      cnt_d      = cnt_q + CNT_W'(1);
      phase_on_d = phase_on_q;
      if (cnt_q == CNT_W'(BLINK_DIV-1)) begin
         cnt_d      = '0;
         phase_on_d = ~phase_on_q;
      end
   end

   // State registers; reset drops any half-built shadow and blanks the display.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         lz_q       <= 1'b0;
         val_q      <= '0;
         bm_q       <= '0;
         dm_q       <= '0;
         shadow_q   <= {NUM_DIGITS{HEX_OFF}};
         hex_q      <= {NUM_DIGITS{HEX_OFF}};
         cnt_q      <= '0;
         phase_on_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         lz_q       <= lz_d;
         val_q      <= val_d;
         bm_q       <= bm_d;
         dm_q       <= dm_d;
         shadow_q   <= shadow_d;
         hex_q      <= hex_d;
         cnt_q      <= cnt_d;
         phase_on_q <= phase_on_d;
      end
   end

   // Blink gate is live so dropping blink_en restores the committed digits right away.
   always_comb begin
      hex = hex_q | {HEX_W{blink_en & ~phase_on_q}};
   end

endmodule
